// File: rtl/uart_tx_fifo_if.sv
// Byte-write and uart_tx launch handshake bundle for uart_tx_fifo.
// o_level exists only when UART_TX_FIFO_LEVEL_EN is defined.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

interface uart_tx_fifo_if #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
);
  logic                   i_wr_en;
  logic [`DATA_WIDTH-1:0] i_wr_data;
  logic                   o_full;
  logic                   o_empty;
  logic                   o_overflow;
  logic                   o_tx;
  logic [`DATA_WIDTH-1:0] o_tx_byte;
  logic                   i_tx_d;
`ifdef UART_TX_FIFO_LEVEL_EN
  logic [AW:0]            o_level;
`endif

  modport slave (
    input  i_wr_en, i_wr_data, i_tx_d,
    output o_full, o_empty, o_overflow, o_tx, o_tx_byte
`ifdef UART_TX_FIFO_LEVEL_EN
    , output o_level
`endif
  );

  modport master (
    output i_wr_en, i_wr_data, i_tx_d,
    input  o_full, o_empty, o_overflow, o_tx, o_tx_byte
`ifdef UART_TX_FIFO_LEVEL_EN
    , input o_level
`endif
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding uart_tx one frame at a time (IDLE -> SEND -> GAP).
// Optional occupancy output o_level: define UART_TX_FIFO_LEVEL_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module uart_tx_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input logic           sysclk,
  input logic           i_rst_n,
  uart_tx_fifo_if.slave bus
);
  localparam int DW = `DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t        state, state_nx;
  logic [AW:0]   wp, rp;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] tx_byte_q;
  logic          tx_d_q, overflow_q;
  logic          full, empty, wr_ok, pop, load;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = (wp == rp);
  assign wr_ok = bus.i_wr_en && !full;

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    load     = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        load     = 1'b1;
        state_nx = SEND;
      end
      SEND: if (bus.i_tx_d && !tx_d_q) begin
        pop      = 1'b1;
        state_nx = GAP;
      end
      // Any edge taken in GAP means i_tx was already low for a full cycle.
      GAP:  if (!bus.i_tx_d) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      wp         <= '0;
      rp         <= '0;
      tx_d_q     <= 1'b0;
      overflow_q <= 1'b0;
      tx_byte_q  <= '0;
    end else begin
      state  <= state_nx;
      tx_d_q <= bus.i_tx_d;
      if (wr_ok)                overflow_q <= overflow_q;
      if (bus.i_wr_en && full)  overflow_q <= 1'b1;
      if (wr_ok)                wp         <= wp + 1'b1;
      if (pop)                  rp         <= rp + 1'b1;
      if (load)                 tx_byte_q  <= mem[rp[AW-1:0]];
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge sysclk) begin
    if (wr_ok) mem[wp[AW-1:0]] <= bus.i_wr_data;
  end

  assign bus.o_full     = full;
  assign bus.o_empty    = empty;
  assign bus.o_overflow = overflow_q;
  assign bus.o_tx       = (state == SEND);
  assign bus.o_tx_byte  = tx_byte_q;
`ifdef UART_TX_FIFO_LEVEL_EN
  assign bus.o_level    = wp - rp;
`endif
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo with a behavioural uart_tx stand-in and a byte scoreboard.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic sysclk = 1'b0;
  logic i_rst_n = 1'b0;
  int   n_cmp = 0, n_bad = 0, cyc = 0;

  uart_tx_fifo_if #(.DEPTH(DEPTH)) fif ();
  uart_tx_fifo #(.DEPTH(DEPTH)) dut (.sysclk(sysclk), .i_rst_n(i_rst_n), .bus(fif));

  always #4 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  logic [7:0] sb [$];

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  // uart_tx stand-in: latches the byte on launch, busy for one frame, then a 1-cycle done pulse.
  logic m_busy = 1'b0, tx_d = 1'b0, gap_pend = 1'b0;
  int   m_cnt = 0, last_done = 0;
  assign fif.i_tx_d = tx_d;

  always @(posedge sysclk) begin
    tx_d <= 1'b0;
    if (tx_d) begin
      last_done <= cyc;
      gap_pend  <= (sb.size() > 0) && i_rst_n;
    end
    if (m_busy) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == FRAME - 1) begin
        m_busy <= 1'b0;
        tx_d   <= 1'b1;
      end
    end else if (!tx_d && fif.o_tx) begin
      m_busy <= 1'b1;
      m_cnt  <= 0;
      if (sb.size() == 0) chk("sb_empty_launch", int'(fif.o_tx_byte), -1);
      else chk("tx_byte", int'(fif.o_tx_byte), int'(sb.pop_front()));
      if (gap_pend) chk("gap_edges", cyc - last_done, 3);
      gap_pend <= 1'b0;
    end
  end

  task automatic wr_byte(input logic [7:0] b, input bit expect_tx);
    @(negedge sysclk);
    fif.i_wr_en   = 1'b1;
    fif.i_wr_data = b;
    if (expect_tx) sb.push_back(b);
    @(posedge sysclk);
    #1 fif.i_wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    @(negedge sysclk);
    while (!(fif.o_empty && !fif.o_tx && !m_busy && !tx_d) && k < 3000) begin
      @(negedge sysclk);
      k++;
    end
    if (k >= 3000) chk({tag, "_timeout"}, 0, 1);
    idle(3);
    chk({tag, "_left"}, sb.size(), 0);
    chk({tag, "_empty"}, int'(fif.o_empty), 1);
  endtask

  initial begin
    int k;
    fif.i_wr_en   = 1'b0;
    fif.i_wr_data = '0;
    idle(3);
    i_rst_n = 1'b1;
    idle(10);
    chk("rst_empty", int'(fif.o_empty), 1);
    chk("rst_full", int'(fif.o_full), 0);
    chk("rst_tx", int'(fif.o_tx), 0);
    chk("rst_tx_byte", int'(fif.o_tx_byte), 0);
    chk("rst_ovf", int'(fif.o_overflow), 0);
`ifdef UART_TX_FIFO_LEVEL_EN
    chk("rst_level", int'(fif.o_level), 0);
`endif

    // single byte latency
    wr_byte(8'hCB, 1'b1);
    chk("lat_tx_k", int'(fif.o_tx), 0);
    chk("lat_empty_k", int'(fif.o_empty), 0);
    @(posedge sysclk); #1;
    chk("lat_tx_k1", int'(fif.o_tx), 1);
    chk("lat_byte_k1", int'(fif.o_tx_byte), 8'hCB);
    drain("single");
    chk("single_tx_low", int'(fif.o_tx), 0);

    // burst fill, in-order serialization with minimal gaps
    for (int i = 1; i <= DEPTH; i++) wr_byte(8'(i), 1'b1);
    chk("burst_full", int'(fif.o_full), 1);
`ifdef UART_TX_FIFO_LEVEL_EN
    chk("burst_level", int'(fif.o_level), DEPTH);
`endif
    drain("burst");
    chk("burst_not_full", int'(fif.o_full), 0);

    // overflow: write while full is dropped, flag sticky
    for (int i = 0; i < DEPTH; i++) wr_byte(8'h40 + 8'(i), 1'b1);
    chk("ovf_pre", int'(fif.o_overflow), 0);
    wr_byte(8'hAA, 1'b0);
    chk("ovf_set", int'(fif.o_overflow), 1);
    drain("ovf");
    chk("ovf_sticky", int'(fif.o_overflow), 1);

    // simultaneous write and pop
    wr_byte(8'h31, 1'b1);
    wr_byte(8'h32, 1'b1);
    wr_byte(8'h33, 1'b1);
`ifdef UART_TX_FIFO_LEVEL_EN
    chk("lvl3_pre", int'(fif.o_level), 3);
`endif
    k = 0;
    while (!tx_d && k < 200) begin
      @(negedge sysclk);
      k++;
    end
    if (k >= 200) chk("pop_wait_timeout", 0, 1);
    fif.i_wr_en   = 1'b1;
    fif.i_wr_data = 8'h34;
    sb.push_back(8'h34);
    @(posedge sysclk);
    #1 fif.i_wr_en = 1'b0;
    chk("simul_tx_low", int'(fif.o_tx), 0);
    chk("simul_empty", int'(fif.o_empty), 0);
`ifdef UART_TX_FIFO_LEVEL_EN
    chk("lvl3_post", int'(fif.o_level), 3);
`endif
    drain("simul");

    // reset during the 4th data bit
    wr_byte(8'h77, 1'b1);
    wr_byte(8'h78, 1'b1);
    k = 0;
    while (!(m_busy && m_cnt == 4 * CPB + 1) && k < 200) begin
      @(negedge sysclk);
      k++;
    end
    if (k >= 200) chk("midframe_timeout", 0, 1);
    chk("pre_rst_empty", int'(fif.o_empty), 0);
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", int'(fif.o_tx), 0);
    chk("mid_rst_empty", int'(fif.o_empty), 1);
    chk("mid_rst_ovf", int'(fif.o_overflow), 0);
    sb.delete();
    idle(3);
    chk("mid_rst_byte", int'(fif.o_tx_byte), 0);
    i_rst_n = 1'b1;
    k = 0;
    while ((m_busy || tx_d) && k < 200) begin
      @(negedge sysclk);
      k++;
    end
    if (k >= 200) chk("uart_finish_timeout", 0, 1);
    idle(2);
    wr_byte(8'h5A, 1'b1);
    @(posedge sysclk); #1;
    chk("post_rst_tx", int'(fif.o_tx), 1);
    chk("post_rst_byte", int'(fif.o_tx_byte), 8'h5A);
    drain("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d want completion", cyc);
    $fatal(1, "timeout");
  end
endmodule
